reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/rob_pkg.sv | 20 ++
 rtl/reorder_buffer.sv | 120 ++++++++++++
 tb/tb_reorder_buffer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared constants and types for the reorder buffer.
package rob_pkg;

   localparam int unsigned ROB_DEPTH = 8;
   localparam int unsigned ROB_TAG_W = 3;
   localparam int unsigned ROB_CNT_W = 4;
   localparam int unsigned ROB_RD_W  = 5;
   localparam int unsigned ROB_DW    = 32;

   typedef logic [ROB_TAG_W-1:0] rob_tag_t;
   typedef logic [ROB_CNT_W-1:0] rob_cnt_t;

   typedef struct packed {
      logic                busy;
      logic                ready;
      logic [ROB_RD_W-1:0] rd;
      logic [ROB_DW-1:0]   data;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// 8-entry in-order-commit reorder buffer with CDB capture and operand query ports.
// Define ROB_BYPASS_EN to enable query forwarding; otherwise query outputs are tied to 0.
module reorder_buffer
   import rob_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                alloc_valid,
   input  logic [ROB_RD_W-1:0] alloc_rd,
   output logic                alloc_ready,
   output rob_tag_t            alloc_tag,
   output logic                rf_allocate,
   input  logic                cdb_valid,
   input  rob_tag_t            cdb_tag,
   input  logic [ROB_DW-1:0]   cdb_data,
   output logic                rf_load,
   output logic [ROB_RD_W-1:0] rf_dest,
   output logic [ROB_DW-1:0]   rf_data,
   output rob_tag_t            commit_tag,
   input  rob_tag_t            qry_tag_a,
   input  rob_tag_t            qry_tag_b,
   output logic                qry_ready_a,
   output logic                qry_ready_b,
   output logic [ROB_DW-1:0]   qry_data_a,
   output logic [ROB_DW-1:0]   qry_data_b
);

   rob_entry_t entries_q [ROB_DEPTH];
   rob_entry_t entries_d [ROB_DEPTH];
   rob_tag_t   head_q, head_d;
   rob_tag_t   tail_q, tail_d;
   rob_cnt_t   count_q, count_d;
   logic       alloc_accept;
   logic       commit;

   // Full check uses the pre-edge count, so a same-cycle commit never frees a slot.
   assign alloc_ready  = rst || (count_q < rob_cnt_t'(ROB_DEPTH));
   assign alloc_tag    = tail_q;
   assign rf_allocate  = alloc_valid && alloc_ready;
   assign alloc_accept = rf_allocate && !flush;

   assign commit     = !rst && !flush && entries_q[head_q].busy && entries_q[head_q].ready;
   assign rf_load    = commit;
   assign rf_dest    = entries_q[head_q].rd;
   assign rf_data    = entries_q[head_q].data;
   assign commit_tag = head_q;

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      if (flush) begin
         for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            entries_d[i].busy  = 1'b0;
            entries_d[i].ready = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (cdb_valid && entries_q[cdb_tag].busy) begin
            entries_d[cdb_tag].ready = 1'b1;
            entries_d[cdb_tag].data  = cdb_data;
         end
         if (commit) begin
            entries_d[head_q].busy  = 1'b0;
            entries_d[head_q].ready = 1'b0;
            head_d                  = head_q + 3'd1;
         end
         // Applied last so allocation wins over a CDB write to the same slot.
         if (alloc_accept) begin
            entries_d[tail_q].busy  = 1'b1;
            entries_d[tail_q].ready = 1'b0;
            entries_d[tail_q].rd    = alloc_rd;
            tail_d                  = tail_q + 3'd1;
         end
         count_d = count_q + rob_cnt_t'(alloc_accept) - rob_cnt_t'(commit);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            entries_q[i].busy  <= 1'b0;
            entries_q[i].ready <= 1'b0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

`ifdef ROB_BYPASS_EN
   logic hit_a, hit_b;

   assign hit_a = cdb_valid && (cdb_tag == qry_tag_a);
   assign hit_b = cdb_valid && (cdb_tag == qry_tag_b);

   assign qry_ready_a = !rst && (hit_a || (entries_q[qry_tag_a].busy && entries_q[qry_tag_a].ready));
   assign qry_ready_b = !rst && (hit_b || (entries_q[qry_tag_b].busy && entries_q[qry_tag_b].ready));
   assign qry_data_a  = rst ? '0 : (hit_a ? cdb_data : entries_q[qry_tag_a].data);
   assign qry_data_b  = rst ? '0 : (hit_b ? cdb_data : entries_q[qry_tag_b].data);
`else
   logic unused_qry;

   assign unused_qry  = ^{qry_tag_a, qry_tag_b};
   assign qry_ready_a = 1'b0;
   assign qry_ready_b = 1'b0;
   assign qry_data_a  = '0;
   assign qry_data_b  = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: allocation order queue plus per-tag result model.
module tb_reorder_buffer;
   import rob_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, alloc_valid, cdb_valid;
   logic [4:0]  alloc_rd;
   rob_tag_t    cdb_tag, qry_tag_a, qry_tag_b;
   logic [31:0] cdb_data;
   logic        alloc_ready, rf_allocate, rf_load, qry_ready_a, qry_ready_b;
   rob_tag_t    alloc_tag, commit_tag;
   logic [4:0]  rf_dest;
   logic [31:0] rf_data, qry_data_a, qry_data_b;

   int n_cmp = 0;
   int n_mis = 0;

   logic [2:0]  exp_q [$];
   logic        m_busy  [8];
   logic        m_ready [8];
   logic [4:0]  m_rd    [8];
   logic [31:0] m_data  [8];
   logic [2:0]  m_tail;

   reorder_buffer dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
      .alloc_tag(alloc_tag), .rf_allocate(rf_allocate),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rf_load(rf_load), .rf_dest(rf_dest), .rf_data(rf_data), .commit_tag(commit_tag),
      .qry_tag_a(qry_tag_a), .qry_tag_b(qry_tag_b),
      .qry_ready_a(qry_ready_a), .qry_ready_b(qry_ready_b),
      .qry_data_a(qry_data_a), .qry_data_b(qry_data_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_qry(input string nm, input rob_tag_t t, input logic r, input logic [31:0] d);
      logic        hit, er;
      hit = cdb_valid && (cdb_tag == t);
      er  = !rst && (hit || (m_busy[t] && m_ready[t]));
`ifdef ROB_BYPASS_EN
      chk({nm, "_ready"}, r, er);
      if (rst) chk({nm, "_data"}, d, 0);
      else if (er) chk({nm, "_data"}, d, hit ? cdb_data : m_data[t]);
`else
      chk({nm, "_ready"}, r, 0);
      chk({nm, "_data"}, d, 0);
`endif
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   // Checks outputs against the model, then advances the model across the coming edge.
   task automatic finish_cyc();
      logic exp_ar, exp_load, acc;
      exp_ar   = rst || (exp_q.size() < 8);
      exp_load = !rst && !flush && (exp_q.size() > 0) && m_ready[exp_q[0]];
      chk("alloc_ready", alloc_ready, exp_ar);
      chk("rf_allocate", rf_allocate, alloc_valid && exp_ar);
      if (!rst) chk("alloc_tag", alloc_tag, m_tail);
      chk("rf_load", rf_load, exp_load);
      if (exp_load && rf_load) begin
         chk("commit_tag", commit_tag, exp_q[0]);
         chk("rf_dest", rf_dest, m_rd[exp_q[0]]);
         chk("rf_data", rf_data, m_data[exp_q[0]]);
      end
      chk_qry("qry_a", qry_tag_a, qry_ready_a, qry_data_a);
      chk_qry("qry_b", qry_tag_b, qry_ready_b, qry_data_b);

      if (rst || flush) begin
         for (int i = 0; i < 8; i++) begin
            m_busy[i]  = 1'b0;
            m_ready[i] = 1'b0;
         end
         exp_q.delete();
         m_tail = 3'd0;
      end else begin
         acc = alloc_valid && (exp_q.size() < 8);
         if (cdb_valid && m_busy[cdb_tag]) begin
            m_ready[cdb_tag] = 1'b1;
            m_data[cdb_tag]  = cdb_data;
         end
         if (exp_load) begin
            m_busy[exp_q[0]]  = 1'b0;
            m_ready[exp_q[0]] = 1'b0;
            void'(exp_q.pop_front());
         end
         if (acc) begin
            m_busy[m_tail]  = 1'b1;
            m_ready[m_tail] = 1'b0;
            m_rd[m_tail]    = alloc_rd;
            exp_q.push_back(m_tail);
            m_tail = m_tail + 3'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      to_neg();
      finish_cyc();
   endtask

   task automatic idle();
      alloc_valid = 1'b0;
      cdb_valid   = 1'b0;
      flush       = 1'b0;
   endtask

   task automatic alloc(input logic [4:0] rd);
      alloc_valid = 1'b1;
      alloc_rd    = rd;
      cyc();
      alloc_valid = 1'b0;
   endtask

   task automatic cdb(input rob_tag_t t, input logic [31:0] d);
      cdb_valid = 1'b1;
      cdb_tag   = t;
      cdb_data  = d;
      cyc();
      cdb_valid = 1'b0;
   endtask

   // Feeds CDB results to pending entries until the buffer drains or the budget expires.
   task automatic drain();
      logic found;
      for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
         found     = 1'b0;
         cdb_valid = 1'b0;
         for (int i = 0; i < exp_q.size(); i++) begin
            if (!found && !m_ready[exp_q[i]]) begin
               found     = 1'b1;
               cdb_valid = 1'b1;
               cdb_tag   = exp_q[i];
               cdb_data  = $urandom;
            end
         end
         cyc();
      end
      idle();
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_rd = '0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
      qry_tag_a = '0; qry_tag_b = '0; m_tail = '0;
      for (int i = 0; i < 8; i++) begin
         m_busy[i] = 1'b0; m_ready[i] = 1'b0; m_rd[i] = '0; m_data[i] = '0;
      end
      alloc_valid = 1'b1;
      to_neg();
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_rf_allocate", rf_allocate, 1);
      chk("rst_rf_load", rf_load, 0);
      finish_cyc();
      alloc_valid = 1'b0;
      cyc();
      rst = 1'b0;

      // Single allocation without CDB traffic never commits.
      alloc_valid = 1'b1; alloc_rd = 5'd5;
      to_neg();
      chk("t37_tag", alloc_tag, 0);
      chk("t37_rf_allocate", rf_allocate, 1);
      finish_cyc();
      idle();
      repeat (6) cyc();
      to_neg();
      chk("t37_noload", rf_load, 0);
      finish_cyc();
      cdb(3'd0, 32'h55);
      cyc();

      // Out-of-order completion, in-order commit.
      flush = 1'b1; cyc(); flush = 1'b0;
      alloc(5'd3);
      alloc(5'd4);
      cdb(3'd1, 32'hBB);
      cdb(3'd0, 32'hAA);
      to_neg();
      chk("t38_load0", rf_load, 1);
      chk("t38_dest0", rf_dest, 3);
      chk("t38_data0", rf_data, 32'hAA);
      finish_cyc();
      to_neg();
      chk("t38_load1", rf_load, 1);
      chk("t38_dest1", rf_dest, 4);
      chk("t38_data1", rf_data, 32'hBB);
      finish_cyc();

      // Full buffer: commit does not free a slot until the next cycle; tail wraps.
      flush = 1'b1; cyc(); flush = 1'b0;
      for (int i = 0; i < 8; i++) alloc(5'(i + 8));
      alloc_valid = 1'b1; alloc_rd = 5'd20;
      cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h100;
      to_neg();
      chk("t39_full", alloc_ready, 0);
      finish_cyc();
      cdb_valid = 1'b0;
      to_neg();
      chk("t39_commit", rf_load, 1);
      chk("t39_still_full", alloc_ready, 0);
      finish_cyc();
      to_neg();
      chk("t39_ready", alloc_ready, 1);
      chk("t39_wrap_tag", alloc_tag, 0);
      finish_cyc();
      alloc_valid = 1'b0;
      drain();

      // Same-cycle forwarding on the query port.
      qry_tag_a = 3'd2;
      cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'h1234;
      to_neg();
`ifdef ROB_BYPASS_EN
      chk("t40_ready", qry_ready_a, 1);
      chk("t40_data", qry_data_a, 32'h1234);
`else
      chk("t40_ready", qry_ready_a, 0);
      chk("t40_data", qry_data_a, 0);
`endif
      finish_cyc();
      idle();

      // Flush overrides a concurrent CDB write and allocation.
      flush = 1'b1; cyc(); flush = 1'b0;
      for (int i = 1; i <= 5; i++) alloc(5'(i));
      cdb(3'd3, 32'h33);
      cdb(3'd4, 32'h44);
      flush = 1'b1; alloc_valid = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h99;
      cyc();
      idle();
      to_neg();
      chk("t41_load", rf_load, 0);
      chk("t41_tag", alloc_tag, 0);
      chk("t41_ready", alloc_ready, 1);
      finish_cyc();

      // Reset mid-stream with six busy entries.
      for (int i = 0; i < 6; i++) alloc(5'(i + 10));
      cdb(3'd0, 32'h77);
      rst = 1'b1; alloc_valid = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd1;
      cyc();
      rst = 1'b0; idle();
      to_neg();
      chk("t42_ready", alloc_ready, 1);
      chk("t42_load", rf_load, 0);
      chk("t42_tag", alloc_tag, 0);
      finish_cyc();

      // Random traffic, including CDB writes to idle slots and rd=0 entries.
      for (int c = 0; c < 400; c++) begin
         alloc_valid = ($urandom_range(0, 99) < 60);
         alloc_rd    = 5'($urandom_range(0, 31));
         cdb_valid   = ($urandom_range(0, 1) == 1);
         cdb_tag     = 3'($urandom_range(0, 7));
         cdb_data    = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            for (int i = 0; i < exp_q.size(); i++)
               if (!m_ready[exp_q[i]] && $urandom_range(0, 1) == 1) cdb_tag = exp_q[i];
         end
         qry_tag_a = 3'($urandom_range(0, 7));
         qry_tag_b = 3'($urandom_range(0, 7));
         flush     = ($urandom_range(0, 99) < 2);
         cyc();
      end
      idle();
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
